// File: rtl/fifo_unpacker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : fifo_unpacker
// Brief    : Drains PAR_READ-word groups from a parallel-read FIFO as a
//            single-word valid/ready stream, word 0 first. Define
//            UNPACK_PREFETCH_EN to pop the next group on the last-word
//            handshake (gapless groups).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module fifo_unpacker #(
  parameter int SIZE     = 16,
  parameter int PAR_READ = 4,
  parameter int IDX_W    = (PAR_READ > 1) ? $clog2(PAR_READ) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     fifo_empty,
  input  logic [SIZE*PAR_READ-1:0] fifo_dout,
  output logic                     fifo_ren,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [SIZE-1:0]          m_data,
  output logic                     m_first,
  output logic                     m_last,
  output logic                     busy
);

  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(PAR_READ - 1);

  typedef enum logic [0:0] {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [IDX_W-1:0]           r_idx;
  logic [IDX_W-1:0]           w_idx_nxt;
  logic [SIZE*PAR_READ-1:0]   r_hold;
  logic                       w_ren;
  logic [SIZE-1:0]            w_words [PAR_READ];

  genvar k;
  generate
    for (k = 0; k < PAR_READ; k++) begin : g_words
      assign w_words[k] = r_hold[k*SIZE +: SIZE];
    end
  endgenerate

  always_comb begin
    w_ren       = 1'b0;
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      LOAD: begin
        w_ren = !fifo_empty;
        if (w_ren) begin
          w_state_nxt = DRAIN;
          w_idx_nxt   = '0;
        end
      end
      DRAIN: begin
        // m_valid is always high here, so m_ready alone marks the handshake
        if (m_ready) begin
          if (r_idx != c_last_idx) begin
            w_idx_nxt = r_idx + 1'b1;
          end else begin
`ifdef UNPACK_PREFETCH_EN
            w_ren = !fifo_empty;
            if (w_ren) begin
              w_idx_nxt = '0;
            end else begin
              w_state_nxt = LOAD;
            end
`else
            w_state_nxt = LOAD;
`endif
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
    // A pop during reset or flush would be lost, so suppress it
    if (!rstn || clear) begin
      w_ren = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      r_state <= LOAD;
      r_idx   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_ren) begin
        r_hold <= fifo_dout;
      end
    end
  end

  assign fifo_ren = w_ren;
  assign m_valid  = (r_state == DRAIN);
  assign busy     = (r_state == DRAIN);
  assign m_data   = w_words[r_idx];
  assign m_first  = m_valid && (r_idx == '0);
  assign m_last   = m_valid && (r_idx == c_last_idx);

endmodule
`default_nettype wire

// File: tb/tb_fifo_unpacker.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_fifo_unpacker
// Brief    : Directed self-checking bench for fifo_unpacker (PAR_READ=4 and 1).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_fifo_unpacker;

  localparam int SIZE = 16;
  localparam int PR   = 4;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 clear;
  logic                 fifo_empty;
  logic [SIZE*PR-1:0]   fifo_dout;
  logic                 fifo_ren;
  logic                 m_valid;
  logic                 m_ready;
  logic [SIZE-1:0]      m_data;
  logic                 m_first;
  logic                 m_last;
  logic                 busy;

  logic                 p1_empty;
  logic [SIZE-1:0]      p1_dout;
  logic                 p1_ren;
  logic                 p1_valid;
  logic                 p1_ready;
  logic [SIZE-1:0]      p1_data;
  logic                 p1_first;
  logic                 p1_last;
  logic                 p1_busy;

  int n_vec = 0;
  int n_err = 0;
  int ren_pulses = 0;

  logic [63:0] g1;
  logic [63:0] g2;
  logic        exp_v [11];
  logic        exp_r [11];
  logic [15:0] exp_d [11];

  fifo_unpacker #(.SIZE(SIZE), .PAR_READ(PR)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_ren   (fifo_ren),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_first    (m_first),
    .m_last     (m_last),
    .busy       (busy)
  );

  fifo_unpacker #(.SIZE(SIZE), .PAR_READ(1)) u_dut_p1 (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (clear),
    .fifo_empty (p1_empty),
    .fifo_dout  (p1_dout),
    .fifo_ren   (p1_ren),
    .m_valid    (p1_valid),
    .m_ready    (p1_ready),
    .m_data     (p1_data),
    .m_first    (p1_first),
    .m_last     (p1_last),
    .busy       (p1_busy)
  );

  always #5 clk = ~clk;

  // fifo_ren is settled mid-cycle, so count pops on the falling edge
  always @(negedge clk) if (fifo_ren === 1'b1) ren_pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    int pops;
    g1 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    g2 = {16'h8888, 16'h7777, 16'h6666, 16'h5555};
`ifdef UNPACK_PREFETCH_EN
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_d = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
              16'h6666, 16'h7777, 16'h8888, 16'h0, 16'h0};
`else
    exp_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_r = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_d = '{16'h0, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0,
              16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h0};
`endif

    rstn       = 1'b0;
    clear      = 1'b0;
    fifo_empty = 1'b0;
    fifo_dout  = g1;
    m_ready    = 1'b1;
    p1_empty   = 1'b1;
    p1_dout    = '0;
    p1_ready   = 1'b1;

    // Reset held with a non-empty FIFO
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_ren",   fifo_ren, 0);
      chk("rst_valid", m_valid,  0);
      chk("rst_data",  m_data,   0);
      chk("rst_first", m_first,  0);
      chk("rst_last",  m_last,   0);
      chk("rst_busy",  busy,     0);
    end
    rstn = 1'b1;
    #1;
    chk("first_ren", fifo_ren, 1);
    p0 = ren_pulses;

    // Single group
    tick();
    fifo_empty = 1'b1;
    for (int w = 0; w < 4; w++) begin
      #1;
      chk("sg_valid", m_valid, 1);
      chk("sg_data",  m_data,  g1[w*16 +: 16]);
      chk("sg_first", m_first, (w == 0) ? 1 : 0);
      chk("sg_last",  m_last,  (w == 3) ? 1 : 0);
      chk("sg_ren",   fifo_ren, 0);
      tick();
    end
    chk("sg_end_valid", m_valid, 0);
    chk("sg_end_busy",  busy,    0);
    chk("sg_pulses",    ren_pulses - p0, 1);

    // Backpressure on word 2
    fifo_empty = 1'b0;
    #1;
    chk("bp_ren0", fifo_ren, 1);
    tick();
    fifo_empty = 1'b1;
    tick();
    tick();
    m_ready = 1'b0;
    #1;
    chk("bp_data_w2", m_data, 16'h3333);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_data",  m_data,   16'h3333);
      chk("bp_hold_valid", m_valid,  1);
      chk("bp_hold_last",  m_last,   0);
      chk("bp_hold_ren",   fifo_ren, 0);
    end
    m_ready = 1'b1;
    tick();
    chk("bp_resume_data", m_data, 16'h4444);
    chk("bp_resume_last", m_last, 1);
    tick();
    chk("bp_end_valid", m_valid, 0);

    // Back-to-back groups
    fifo_dout  = g1;
    fifo_empty = 1'b0;
    pops = 0;
    for (int c = 0; c < 11; c++) begin
      #1;
      chk("b2b_ren",   fifo_ren, exp_r[c]);
      chk("b2b_valid", m_valid,  exp_v[c]);
      if (exp_v[c]) chk("b2b_data", m_data, exp_d[c]);
      if (fifo_ren === 1'b1) pops++;
      tick();
      if (pops == 1) fifo_dout = g2;
      if (pops == 2) fifo_empty = 1'b1;
    end

    // Clear mid-group
    fifo_dout  = g1;
    fifo_empty = 1'b0;
    #1;
    chk("clr_pop", fifo_ren, 1);
    tick();
    fifo_empty = 1'b1;
    #1;
    chk("clr_w0", m_data, 16'h1111);
    tick();
    chk("clr_w1", m_data, 16'h2222);
    clear      = 1'b1;
    fifo_empty = 1'b0;
    #1;
    chk("clr_ren_drain", fifo_ren, 0);
    tick();
    chk("clr_valid", m_valid,  0);
    chk("clr_busy",  busy,     0);
    chk("clr_ren_load", fifo_ren, 0);
    clear     = 1'b0;
    fifo_dout = g2;
    #1;
    chk("clr_repop", fifo_ren, 1);
    tick();
    fifo_empty = 1'b1;
    #1;
    chk("clr_new_data",  m_data,  16'h5555);
    chk("clr_new_first", m_first, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("clr_drained", m_valid, 0);

    // PAR_READ=1 instance
    p1_dout  = 16'hABCD;
    p1_empty = 1'b0;
    #1;
    chk("p1_ren0", p1_ren, 1);
    tick();
    p1_dout = 16'h1234;
    #1;
    chk("p1_valid0", p1_valid, 1);
    chk("p1_data0",  p1_data,  16'hABCD);
    chk("p1_first0", p1_first, 1);
    chk("p1_last0",  p1_last,  1);
`ifdef UNPACK_PREFETCH_EN
    chk("p1_ren1", p1_ren, 1);
    tick();
    p1_empty = 1'b1;
    #1;
`else
    chk("p1_ren1", p1_ren, 0);
    tick();
    chk("p1_bubble", p1_valid, 0);
    chk("p1_ren2",   p1_ren,   1);
    tick();
    p1_empty = 1'b1;
    #1;
`endif
    chk("p1_valid1", p1_valid, 1);
    chk("p1_data1",  p1_data,  16'h1234);
    chk("p1_first1", p1_first, 1);
    chk("p1_last1",  p1_last,  1);
    chk("p1_ren_empty", p1_ren, 0);
    tick();
    chk("p1_end_valid", p1_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
